// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI target endpoint, all four SPI modes.
//   The SCLK, MOSI and CS_n inputs are synchronised into i_Clk and edge-detected.
//   MOSI is deserialised MSB-first into o_RX_Byte, and each complete byte is flagged by a
//   one-cycle o_RX_DV pulse.
//   A single-entry holding register feeds the MISO shifter. When the holding register is
//   empty, IDLE_BYTE is shifted out instead.
// Ports:
//   i_Clk, i_Rst               system clock, async active-high reset
//   i_TX_Byte, i_TX_DV         byte to send on MISO, one-cycle qualifier
//   o_TX_Ready                 holding register empty
//   o_RX_DV, o_RX_Byte         received-byte pulse and last received byte
//   i_SPI_Clk/MOSI/CS_n        asynchronous SPI bus inputs
//   o_SPI_MISO, o_SPI_MISO_En  MISO data and its output enable
module spi_peripheral #(
    parameter int unsigned SPI_MODE  = 0,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam int unsigned CNT_W = 3;
    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;

    logic             r_sclk_s1, r_sclk_s2, r_sclk_prev;
    logic             r_mosi_s1, r_mosi_s2;
    logic             r_cs_s1, r_cs_s2, r_cs_prev;

    logic [CNT_W-1:0] r_bit_cnt;
    logic [6:0]       r_rx_shift;
    logic [6:0]       r_tx_rest;
    logic [7:0]       r_hold;

    logic             w_sclk_rise, w_sclk_fall, w_lead, w_trail;
    logic             w_sample_edge, w_shift_edge;
    logic             w_cs_fall, w_cs_rise;
    logic             w_load, w_do_sample, w_do_shift;
    logic [7:0]       w_load_byte;
    logic [7:0]       w_rx_next;

    // Edge qualification on the synchronised bus.
    assign w_sclk_rise   = r_sclk_s2 & ~r_sclk_prev;
    assign w_sclk_fall   = ~r_sclk_s2 & r_sclk_prev;
    assign w_lead        = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail       = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = CPHA ? w_trail : w_lead;
    assign w_shift_edge  = CPHA ? w_lead  : w_trail;
    assign w_cs_fall     = r_cs_prev & ~r_cs_s2;
    assign w_cs_rise     = ~r_cs_prev & r_cs_s2;

    // Holding register first, then a same-cycle bypass, else the underrun byte.
    assign w_load_byte = ~o_TX_Ready ? r_hold : (i_TX_DV ? i_TX_Byte : IDLE_BYTE);
    assign w_rx_next   = {r_rx_shift, r_mosi_s2};

    // Next state and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_do_sample  = 1'b0;
        w_do_shift   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_load       = ~CPHA;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_do_sample = w_sample_edge;
                    // A shift edge at bit 0 starts a new byte; otherwise it advances MISO.
                    w_load      = w_shift_edge & (r_bit_cnt == '0);
                    w_do_shift  = w_shift_edge & (r_bit_cnt != '0);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Synchronisers, shifters, handshake and registered outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sclk_s1     <= CPOL;
            r_sclk_s2     <= CPOL;
            r_sclk_prev   <= CPOL;
            r_mosi_s1     <= 1'b0;
            r_mosi_s2     <= 1'b0;
            // CS history starts "asserted" so that a CS already low out of reset does not
            // count as a falling edge. A real rising edge must be seen first.
            r_cs_s1       <= 1'b0;
            r_cs_s2       <= 1'b0;
            r_cs_prev     <= 1'b0;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_rest     <= IDLE_BYTE[6:0];
            r_hold        <= '0;
            o_TX_Ready    <= 1'b1;
            o_RX_DV       <= 1'b0;
            o_RX_Byte     <= '0;
            o_SPI_MISO    <= IDLE_BYTE[7];
            o_SPI_MISO_En <= 1'b0;
        end else begin
            r_sclk_s1     <= i_SPI_Clk;
            r_sclk_s2     <= r_sclk_s1;
            r_sclk_prev   <= r_sclk_s2;
            r_mosi_s1     <= i_SPI_MOSI;
            r_mosi_s2     <= r_mosi_s1;
            r_cs_s1       <= i_SPI_CS_n;
            r_cs_s2       <= r_cs_s1;
            r_cs_prev     <= r_cs_s2;
            o_RX_DV       <= 1'b0;
            o_SPI_MISO_En <= (w_state_next == ST_ACTIVE);

            // A load empties the holding register, or consumes a bypassed byte.
            if (w_load) begin
                o_SPI_MISO <= w_load_byte[7];
                r_tx_rest  <= w_load_byte[6:0];
                o_TX_Ready <= 1'b1;
            end else begin
                if (w_do_shift) begin
                    o_SPI_MISO <= r_tx_rest[6];
                    r_tx_rest  <= {r_tx_rest[5:0], 1'b0};
                end
                if (o_TX_Ready && i_TX_DV) begin
                    r_hold     <= i_TX_Byte;
                    o_TX_Ready <= 1'b0;
                end
            end

            // Leaving ACTIVE drops any partial byte. Stale shifter bits are flushed by the next 8 samples.
            if (w_state_next == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_do_sample) begin
                r_rx_shift <= w_rx_next[6:0];
                r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                if (r_bit_cnt == CNT_W'(7)) begin
                    o_RX_Byte <= w_rx_next;
                    o_RX_DV   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed bench for spi_peripheral in modes 0 (u_m0) and 3 (u_m3).
//   The bench acts as the SPI controller: it drives each bus and records the MISO bits at the sample edges.
//   Every byte the controller completes is queued as an expected RX byte.
//   A per-cycle compare process matches each o_RX_DV pulse against that queue.
//   The same process checks that o_RX_Byte holds between pulses.
//   It also checks that o_SPI_MISO_En follows CS once CS has been stable for a while.
module tb_spi_peripheral;

    localparam int unsigned H = 5;   // SCLK half period in i_Clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sclk, mosi, cs_n, tx_dv;
    logic [1:0] tx_ready, rx_dv, miso, miso_en;
    logic [7:0] tx_byte [2];
    logic [7:0] rx_byte [2];

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] last_rx [2];
    logic [1:0] armed;
    logic [1:0] cs_seen;
    int         stable [2];
    logic [15:0] got;

    always #5 clk = ~clk;

    spi_peripheral #(.SPI_MODE(0), .IDLE_BYTE(8'hFF)) u_m0 (
        .i_Clk(clk), .i_Rst(rst),
        .i_TX_Byte(tx_byte[0]), .i_TX_DV(tx_dv[0]), .o_TX_Ready(tx_ready[0]),
        .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
        .i_SPI_Clk(sclk[0]), .i_SPI_MOSI(mosi[0]), .i_SPI_CS_n(cs_n[0]),
        .o_SPI_MISO(miso[0]), .o_SPI_MISO_En(miso_en[0])
    );

    spi_peripheral #(.SPI_MODE(3), .IDLE_BYTE(8'hFF)) u_m3 (
        .i_Clk(clk), .i_Rst(rst),
        .i_TX_Byte(tx_byte[1]), .i_TX_DV(tx_dv[1]), .o_TX_Ready(tx_ready[1]),
        .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
        .i_SPI_Clk(sclk[1]), .i_SPI_MOSI(mosi[1]), .i_SPI_CS_n(cs_n[1]),
        .o_SPI_MISO(miso[1]), .o_SPI_MISO_En(miso_en[1])
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int d, input logic [7:0] b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    task automatic cs_low(input int d);
        @(negedge clk);
        cs_n[d] = 1'b0;
        cyc(H);
    endtask

    task automatic cs_high(input int d);
        cyc(H);
        cs_n[d] = 1'b1;
        cyc(2 * H);
    endtask

    // Controller side: d=0 runs mode 0, d=1 runs mode 3. data is sent MSB-first from bit n-1.
    task automatic spi_bits(input int d, input logic [15:0] data, input int n,
                            output logic [15:0] rcv);
        rcv = '0;
        for (int i = 0; i < n; i++) begin
            logic b;
            b = data[n-1-i];
            if (d == 0) begin
                mosi[d] = b;
                cyc(H);
                rcv = {rcv[14:0], miso[d]};
                if ((i + 1) % 8 == 0) push_exp(d, 8'(data >> (n - 1 - i)));
                sclk[d] = ~sclk[d];
                cyc(H);
                sclk[d] = ~sclk[d];
            end else begin
                sclk[d] = ~sclk[d];
                mosi[d] = b;
                cyc(H);
                rcv = {rcv[14:0], miso[d]};
                if ((i + 1) % 8 == 0) push_exp(d, 8'(data >> (n - 1 - i)));
                sclk[d] = ~sclk[d];
                cyc(H);
            end
        end
    endtask

    task automatic spi_frame(input int d, input logic [15:0] data, input int n,
                             output logic [15:0] rcv);
        cs_low(d);
        spi_bits(d, data, n, rcv);
        cs_high(d);
    endtask

    task automatic tx_load(input int d, input logic [7:0] b);
        @(negedge clk);
        tx_byte[d] = b;
        tx_dv[d]   = 1'b1;
        @(negedge clk);
        tx_dv[d]   = 1'b0;
    endtask

    // Per-cycle compare against the expected-byte queues and the CS model.
    initial begin
        cs_seen = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                armed   = 2'b00;
                last_rx = '{8'h00, 8'h00};
                stable  = '{0, 0};
                cs_seen = cs_n;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    logic [7:0] e;
                    logic       have;
                    if (cs_n[d] !== cs_seen[d]) stable[d] = 0;
                    else                        stable[d]++;
                    cs_seen[d] = cs_n[d];
                    if (cs_n[d]) armed[d] = 1'b1;
                    if (rx_dv[d]) begin
                        have = 1'b0;
                        e    = '0;
                        if (d == 0 && exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
                        if (d == 1 && exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
                        if (have) begin
                            check($sformatf("rx_byte_d%0d", d), 16'(rx_byte[d]), 16'(e));
                            last_rx[d] = e;
                        end else begin
                            total++;
                            bad++;
                            $display("FAIL rx_dv_unexpected_d%0d: got pulse with %h expected none", d, rx_byte[d]);
                        end
                    end else begin
                        check($sformatf("rx_hold_d%0d", d), 16'(rx_byte[d]), 16'(last_rx[d]));
                    end
                    if (stable[d] >= 6)
                        check($sformatf("miso_en_d%0d", d), 16'(miso_en[d]), 16'(armed[d] & ~cs_n[d]));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        sclk       = 2'b10;       // mode 3 idles SCLK high
        mosi       = 2'b00;
        cs_n       = 2'b11;
        tx_dv      = 2'b00;
        tx_byte[0] = 8'h00;
        tx_byte[1] = 8'h00;
        cyc(3);
        check("rst_rx_dv",    16'(rx_dv),      16'h0);
        check("rst_rx_byte",  16'(rx_byte[0]), 16'h00);
        check("rst_tx_ready", 16'(tx_ready),   16'h3);
        check("rst_miso_en",  16'(miso_en),    16'h0);
        check("rst_miso",     16'(miso),       16'h3);
        @(negedge clk);
        rst = 1'b0;
        cyc(5);

        // Mode 0: TX A5, RX 3C; the CS-fall load frees the holding register.
        tx_load(0, 8'hA5);
        cyc(1);
        check("m0_ready_held", 16'(tx_ready[0]), 16'h0);
        cs_low(0);
        check("m0_ready_csfall", 16'(tx_ready[0]), 16'h1);
        spi_bits(0, 16'h003C, 8, got);
        cs_high(0);
        check("m0_miso_a5", got[7:0], 16'hA5);
        check("m0_rx_3c", 16'(rx_byte[0]), 16'h3C);

        // Mode 3: TX 81, RX 7E.
        tx_load(1, 8'h81);
        spi_frame(1, 16'h007E, 8, got);
        check("m3_miso_81", got[7:0], 16'h81);
        check("m3_rx_7e", 16'(rx_byte[1]), 16'h7E);

        // Underrun: nothing loaded, IDLE_BYTE goes out.
        spi_frame(0, 16'h0055, 8, got);
        check("underrun_miso", got[7:0], 16'hFF);
        check("underrun_rx", 16'(rx_byte[0]), 16'h55);

        // Two bytes under one CS; 22 is written after 11 has been loaded.
        tx_load(0, 8'h11);
        fork
            spi_frame(0, 16'hA1B2, 16, got);
            begin
                cyc(20);
                tx_load(0, 8'h22);
            end
        join
        check("b2b_miso", got, 16'h1122);
        check("b2b_rx_last", 16'(rx_byte[0]), 16'hB2);
        check("b2b_ready", 16'(tx_ready[0]), 16'h1);

        // Partial byte (first 5 bits of F0) then a full 0F.
        spi_frame(0, 16'h001E, 5, got);
        check("partial_rx_kept", 16'(rx_byte[0]), 16'hB2);
        spi_frame(0, 16'h000F, 8, got);
        check("after_partial_miso", got[7:0], 16'hFF);
        check("after_partial_rx", 16'(rx_byte[0]), 16'h0F);

        // Reset after 3 bits of a transfer; the rest of it must be ignored.
        cs_low(0);
        tx_load(0, 8'h99);
        check("pre_rst_ready", 16'(tx_ready[0]), 16'h0);
        spi_bits(0, 16'h0006, 3, got);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rx_dv",    16'(rx_dv[0]),    16'h0);
        check("midrst_rx_byte",  16'(rx_byte[0]),  16'h00);
        check("midrst_tx_ready", 16'(tx_ready[0]), 16'h1);
        check("midrst_miso_en",  16'(miso_en[0]),  16'h0);
        check("midrst_miso",     16'(miso[0]),     16'h1);
        cyc(3);
        rst = 1'b0;
        spi_bits(0, 16'h0018, 5, got);
        check("post_rst_ignored", 16'(miso_en[0]), 16'h0);
        cs_high(0);
        spi_frame(0, 16'h00C3, 8, got);
        check("post_rst_miso", got[7:0], 16'hFF);
        check("post_rst_rx", 16'(rx_byte[0]), 16'hC3);

        cyc(20);
        check("rx_pending_d0", 16'(exp_q0.size()), 16'h0);
        check("rx_pending_d1", 16'(exp_q1.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI peripheral (slave) endpoint: the responder for the team's SPI controller on the same four-wire bus.
- Oversamples SCLK, MOSI and CS_n in the i_Clk domain.
- Deserialises MOSI into bytes reported with a one-cycle valid pulse; serialises a user-supplied byte onto MISO, MSB first.
- Sits beside the controller in the loopback bench and in any design acting as an SPI target.

Parameters:
SPI_MODE, 0, SPI mode 0-3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
IDLE_BYTE, 8'hFF, byte shifted out on MISO when no TX byte is pending (underrun)

Ports:
i_Clk  input  1  system clock; all logic on rising edge
i_Rst  input  1  reset, asynchronous, active-high
i_TX_Byte  input  8  byte to transmit on MISO
i_TX_DV  input  1  one-cycle pulse qualifying i_TX_Byte
o_TX_Ready  output  1  TX holding register empty; i_TX_DV accepted only while high
o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a complete received byte
o_RX_Byte  output  8  last byte received on MOSI
i_SPI_Clk  input  1  SCLK from controller (asynchronous)
i_SPI_MOSI  input  1  MOSI (asynchronous)
i_SPI_CS_n  input  1  chip select, active-low (asynchronous)
o_SPI_MISO  output  1  MISO data
o_SPI_MISO_En  output  1  MISO output enable; high only while CS asserted

Behaviour:
- Clock/reset: one clock i_Clk; reset asynchronous, active-high.
- Reset values:
  - o_RX_DV=0, o_RX_Byte=0, o_TX_Ready=1, o_SPI_MISO_En=0.
  - o_SPI_MISO = IDLE_BYTE[7].
  - Bit counter 0; holding register empty; FSM = IDLE.
- Synchronisers:
  - i_SPI_Clk, i_SPI_MOSI and i_SPI_CS_n each pass through a 2-FF synchroniser.
  - Edges are detected on the synchronised SCLK and CS_n (current vs previous).
  - MOSI is taken from the same synchroniser stage as SCLK.
- Requirement on the bus: each SCLK high and low phase lasts ≥4 i_Clk periods; CS_n setup/hold to the first/last SCLK edge ≥4 i_Clk periods.
- Edge definitions:
  - Leading edge = rising when CPOL=0, falling when CPOL=1; trailing edge is the opposite.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- FSM IDLE (CS_n high):
  - MISO_En=0; bit counter held at 0; SCLK edges ignored.
  - Synced CS_n falling -> ACTIVE, MISO_En=1 the next cycle.
  - If CPHA=0, a load occurs on this same cycle.
- FSM ACTIVE (CS_n low):
  - Sample edge: MOSI is shifted into the RX shift register LSB-side (MSB received first); bit counter increments mod 8.
  - On the 8th sample: o_RX_Byte <= assembled byte and o_RX_DV=1, both in the cycle after the detected edge; o_RX_DV stays high exactly one cycle.
  - Shift edge: the next TX bit is driven on o_SPI_MISO.
  - Synced CS_n rising -> IDLE.
- Load point:
  - The TX shift register is loaded from the holding register (then o_TX_Ready=1), or from IDLE_BYTE if the holding register is empty. Bit 7 is driven immediately.
  - CPHA=0: load on CS fall, and on the shift edge following each 8th sample while CS stays low.
  - CPHA=1: load on the shift edge while bit counter = 0.
- TX handshake:
  - i_TX_DV while o_TX_Ready=1 captures i_TX_Byte; o_TX_Ready=0 from the next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored; the held byte is kept.
  - i_TX_DV in the same cycle as a load with the holding register empty: the byte bypasses straight into the shift register, and o_TX_Ready stays 1.
- Boundary conditions:
  - CS deasserted mid-byte: partial RX byte discarded, no o_RX_DV, bit counter cleared. The holding register is preserved; the partial TX byte is discarded.
  - Back-to-back bytes under continuous CS: no gap bits; RX_DV pulses once per 8 samples.
  - Reset mid-transfer: everything returns to reset values immediately. Resynchronisation happens on the next CS falling edge only; a transfer already in progress with CS low is ignored until CS high is seen.
  - o_RX_Byte holds its value until the next complete byte.

Test Plan:
- SPI_MODE=0; load TX 8'hA5; controller sends 8'h3C -> MISO carries A5 MSB-first; o_RX_DV one pulse, o_RX_Byte=3C; o_TX_Ready returns to 1 at the CS-fall load.
- SPI_MODE=3; TX 8'h81; controller sends 8'h7E -> MISO=81, o_RX_Byte=7E; no RX_DV before the 8th trailing edge.
- No TX loaded; controller sends 8'h55 -> MISO=FF (IDLE_BYTE), o_RX_Byte=55.
- Two bytes under one CS (TX 11 then 22, second loaded after the first load) -> MISO 11,22; o_RX_DV pulses twice; no gap bits.
- CS raised after 5 bits of 8'hF0, then a full byte 8'h0F -> no RX_DV for the partial byte; one RX_DV with 0F.
- i_Rst asserted after 3 bits -> outputs at reset values immediately; the next full CS transfer of 8'hC3 is received correctly.
